// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter feeding a sequence detector's x_in, with idle-level gaps between frames.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even parity bit to every frame.
module serial_pattern_tx #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   MSB_FIRST  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifndef SERIAL_PATTERN_TX_PARITY_EN
    localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(WIDTH - 2);
`endif

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
    logic parity_bit;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             load_head;
    logic             next_head;
    logic [WIDTH-1:0] shifted;

    // The head bit is always the one on x_out; shifting moves the next bit into the head.
    assign load_head = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
    assign next_head = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];
    assign shifted   = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    // Outputs are registered, so each transition loads the values for the cycle being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            x_out      <= IDLE_LEVEL;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg      <= data_in;
                        bit_cnt    <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                        state      <= SHIFT;
                        x_out      <= load_head;
                        bit_valid  <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        frame_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg   <= shifted;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_CNT) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        state      <= PARITY;
                        x_out      <= parity_bit;
                        frame_done <= 1'b1;
`else
                        if (GAP_CYCLES == 0) begin
                            state      <= IDLE;
                            load_ready <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                        x_out      <= IDLE_LEVEL;
                        bit_valid  <= 1'b0;
                        frame_done <= 1'b0;
`endif
                    end else begin
                        x_out <= next_head;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        frame_done <= 1'b0;
`else
                        frame_done <= (bit_cnt == PENULT_CNT);
`endif
                    end
                end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                PARITY: begin
                    if (GAP_CYCLES == 0) begin
                        state      <= IDLE;
                        load_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                    x_out      <= IDLE_LEVEL;
                    bit_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
`endif
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state      <= IDLE;
                        load_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: two instances (MSB-first with gap, LSB-first without gap)
// checked cycle by cycle against a frame-level model of the expected line.
module tb_serial_pattern_tx;

    localparam int W = 8;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL    = W + PAR;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         valid_a = 1'b0;
    logic         valid_b = 1'b0;
    logic         lr_a, x_a, bv_a, busy_a, fd_a;
    logic         lr_b, x_b, bv_b, busy_b, fd_b;
    logic [4:0]   obs_a, obs_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign obs_a = {x_a, bv_a, fd_a, busy_a, lr_a};
    assign obs_b = {x_b, bv_b, fd_b, busy_b, lr_b};

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP_A), .IDLE_LEVEL(1'b1), .MSB_FIRST(1)) dut_a (
        .clock(clock), .reset(reset), .data_in(data_a), .load_valid(valid_a),
        .load_ready(lr_a), .x_out(x_a), .bit_valid(bv_a), .busy(busy_a), .frame_done(fd_a)
    );

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP_B), .IDLE_LEVEL(1'b0), .MSB_FIRST(0)) dut_b (
        .clock(clock), .reset(reset), .data_in(data_b), .load_valid(valid_b),
        .load_ready(lr_b), .x_out(x_b), .bit_valid(bv_b), .busy(busy_b), .frame_done(fd_b)
    );

    // Expected {x_out, bit_valid, frame_done, busy, load_ready} for cycle k after a handshake.
    function automatic logic [4:0] model_out(int k, logic [W-1:0] word, int gap, bit msb, logic idle);
        logic b;
        int   idx;
        if (k <= FL) begin
            if (k <= W) begin
                idx = msb ? (W - k) : (k - 1);
                b   = word[idx];
            end else begin
                b = ^word;
            end
            return {b, 1'b1, (k == FL), 1'b1, 1'b0};
        end
        if (k <= FL + gap) return {idle, 1'b0, 1'b0, 1'b1, 1'b0};
        return {idle, 4'b0001};
    endfunction

    task automatic test_reset();
        reset   = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        data_a  = W'($urandom);
        data_b  = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (obs_a !== 5'b10001) begin
                errors++;
                $display("[TB] FAIL reset_a edge=%0d got %b want %b", i, obs_a, 5'b10001);
            end
            checks++;
            if (obs_b !== 5'b00001) begin
                errors++;
                $display("[TB] FAIL reset_b edge=%0d got %b want %b", i, obs_b, 5'b00001);
            end
        end
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (obs_a !== 5'b10001) begin
            errors++;
            $display("[TB] FAIL no_capture_a got %b want %b", obs_a, 5'b10001);
        end
        checks++;
        if (obs_b !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL no_capture_b got %b want %b", obs_b, 5'b00001);
        end
    endtask

    task automatic test_msb_frame();
        logic [W-1:0] word;
        logic [4:0]   exp;
        @(negedge clock);
        for (int f = 0; f < 4; f++) begin
            word = (f == 0) ? 8'hA5 : W'($urandom);
            checks++;
            if (lr_a !== 1'b1) begin
                errors++;
                $display("[TB] FAIL msb_ready frame=%0d got %b want 1", f, lr_a);
            end
            data_a  = word;
            valid_a = 1'b1;
            @(posedge clock);
            for (int k = 1; k <= FL + GAP_A + 1; k++) begin
                @(negedge clock);
                valid_a = 1'b0;
                data_a  = W'($urandom);
                exp = model_out(k, word, GAP_A, 1'b1, 1'b1);
                checks++;
                if (obs_a !== exp) begin
                    errors++;
                    $display("[TB] FAIL msb_frame word=%h k=%0d got %b want %b", word, k, obs_a, exp);
                end
            end
        end
    endtask

    task automatic test_lsb_frame();
        logic [W-1:0] word;
        logic [4:0]   exp;
        @(negedge clock);
        for (int f = 0; f < 4; f++) begin
            word = (f == 0) ? 8'h01 : W'($urandom);
            data_b  = word;
            valid_b = 1'b1;
            @(posedge clock);
            for (int k = 1; k <= FL + GAP_B + 1; k++) begin
                @(negedge clock);
                valid_b = 1'b0;
                data_b  = W'($urandom);
                exp = model_out(k, word, GAP_B, 1'b0, 1'b0);
                checks++;
                if (obs_b !== exp) begin
                    errors++;
                    $display("[TB] FAIL lsb_frame word=%h k=%0d got %b want %b", word, k, obs_b, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        @(negedge clock);
        data_b  = 8'hFF;
        valid_b = 1'b1;
        @(posedge clock);
        // load_valid stays high throughout; data_in churns while busy and must be ignored.
        for (int k = 1; k <= FL + GAP_B + 1; k++) begin
            @(negedge clock);
            data_b = (k == FL + GAP_B + 1) ? 8'h00 : W'($urandom);
            exp = model_out(k, 8'hFF, GAP_B, 1'b0, 1'b0);
            checks++;
            if (obs_b !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_first k=%0d got %b want %b", k, obs_b, exp);
            end
        end
        @(posedge clock);
        for (int k = 1; k <= FL + GAP_B + 1; k++) begin
            @(negedge clock);
            valid_b = 1'b0;
            data_b  = W'($urandom);
            exp = model_out(k, 8'h00, GAP_B, 1'b0, 1'b0);
            checks++;
            if (obs_b !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_second k=%0d got %b want %b", k, obs_b, exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] word;
        logic [4:0]   exp;
        @(negedge clock);
        word    = W'($urandom);
        data_a  = word;
        valid_a = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            valid_a = 1'b0;
            exp = model_out(k, word, GAP_A, 1'b1, 1'b1);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("[TB] FAIL abort_pre k=%0d got %b want %b", k, obs_a, exp);
            end
        end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if (obs_a !== 5'b10001) begin
            errors++;
            $display("[TB] FAIL abort_idle got %b want %b", obs_a, 5'b10001);
        end
        checks++;
        if (obs_b !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL abort_idle_b got %b want %b", obs_b, 5'b00001);
        end
        word    = W'($urandom);
        data_a  = word;
        valid_a = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= FL + GAP_A + 1; k++) begin
            @(negedge clock);
            valid_a = 1'b0;
            exp = model_out(k, word, GAP_A, 1'b1, 1'b1);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("[TB] FAIL abort_reload word=%h k=%0d got %b want %b", word, k, obs_a, exp);
            end
        end
    endtask

    initial begin
        $display("[TB] serial_pattern_tx bench start, frame length %0d", FL);
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
